// File: rtl/gate_bank.sv
// Debounced N-input logic gate driving one LED; a debounced mode button
// steps the reduction function through AND, OR, XOR and NAND.
module gate_bank #(
    parameter int unsigned N_IN           = 2,
    parameter int unsigned DEB_CYCLES     = 250000,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] btn_n,
    input  logic            mode_btn_n,
    output logic            led,
    output logic [1:0]      mode,
    output logic [N_IN-1:0] level
);

    localparam int unsigned NCH  = N_IN + 1;
    localparam int unsigned CW   = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        M_AND  = 2'd0,
        M_OR   = 2'd1,
        M_XOR  = 2'd2,
        M_NAND = 2'd3
    } mode_e;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1_q, sync2_q, s;
    logic [NCH-1:0] stable_q, stable_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic           mode_rise;
    mode_e          state_q, state_d;
    logic           result_q, result_d;

    // Mode button rides along as the top channel so it shares the debouncer.
    assign raw = {mode_btn_n, btn_n};
    assign s   = ~sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            cnt_d[ch] = '0;
            if (s[ch] != stable_q[ch]) begin
                if (cnt_q[ch] == CMAX) begin
                    stable_d[ch] = s[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Advancing on the accepted rise keeps mode aligned with the level update edge.
    assign mode_rise = stable_d[N_IN] & ~stable_q[N_IN];

    always_comb begin
        state_d = state_q;
        if (mode_rise) begin
            unique case (state_q)
                M_AND:   state_d = M_OR;
                M_OR:    state_d = M_XOR;
                M_XOR:   state_d = M_NAND;
                M_NAND:  state_d = M_AND;
                default: state_d = M_AND;
            endcase
        end
    end

    always_comb begin
        result_d = 1'b0;
        unique case (state_q)
            M_AND:   result_d = &stable_q[N_IN-1:0];
            M_OR:    result_d = |stable_q[N_IN-1:0];
            M_XOR:   result_d = ^stable_q[N_IN-1:0];
            M_NAND:  result_d = ~&stable_q[N_IN-1:0];
            default: result_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= M_AND;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign led   = result_q ^ LED_ACTIVE_LOW;
    assign mode  = state_q;
    assign level = stable_q[N_IN-1:0];

endmodule

// File: tb/tb_gate_bank.sv
// Directed bench for gate_bank: a 3-input active-low-LED instance and an
// 8-input active-high-LED instance, both with a 4-cycle debounce.
module tb_gate_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] btn_n;
    logic       mode_btn_n;
    logic       led;
    logic [1:0] mode;
    logic [2:0] level;

    logic [7:0] btn_n_b;
    logic       mode_btn_n_b;
    logic       led_b;
    logic [1:0] mode_b;
    logic [7:0] level_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_bank #(.N_IN(3), .DEB_CYCLES(4), .LED_ACTIVE_LOW(1'b1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_n      (btn_n),
        .mode_btn_n (mode_btn_n),
        .led        (led),
        .mode       (mode),
        .level      (level)
    );

    gate_bank #(.N_IN(8), .DEB_CYCLES(4), .LED_ACTIVE_LOW(1'b0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_n      (btn_n_b),
        .mode_btn_n (mode_btn_n_b),
        .led        (led_b),
        .mode       (mode_b),
        .level      (level_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_a();
        mode_btn_n = 1'b0;
        tick(10);
        mode_btn_n = 1'b1;
        tick(10);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b1;
        btn_n        = 3'b111;
        mode_btn_n   = 1'b1;
        btn_n_b      = 8'hFF;
        mode_btn_n_b = 1'b1;
        tick(2);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("rst_led", led, 1);
        check("rst_mode", mode, 0);
        check("rst_level", level, 0);
        check("rst_led_b", led_b, 0);
        tick(3);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_led", led, 1);
            check("idle_mode", mode, 0);
            check("idle_level", level, 0);
        end

        // Short glitch on btn0 is discarded
        btn_n = 3'b110;
        tick(3);
        btn_n = 3'b111;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_level", level, 0);
        end

        // Steady press qualifies after 2 + DEB_CYCLES edges
        btn_n = 3'b000;
        tick(5);
        check("deb_level_early", level, 3'b000);
        tick(1);
        check("deb_level", level, 3'b111);
        check("deb_led_same_edge", led, 1);
        tick(1);
        check("deb_led_and", led, 0);

        // level = 011 then step through the modes
        btn_n = 3'b100;
        tick(10);
        check("lvl011", level, 3'b011);
        check("and011_led", led, 1);

        mode_btn_n = 1'b0;
        tick(5);
        check("mode_early", mode, 0);
        tick(1);
        check("mode_edge", mode, 1);
        tick(4);
        mode_btn_n = 1'b1;
        tick(10);
        check("mode_or", mode, 1);
        check("led_or", led, 0);

        press_a();
        check("mode_xor", mode, 2);
        check("led_xor", led, 1);
        press_a();
        check("mode_nand", mode, 3);
        check("led_nand", led, 0);
        press_a();
        check("mode_and", mode, 0);
        check("led_and", led, 1);

        // Bouncing mode button then held low: one increment
        for (int i = 0; i < 10; i++) begin
            mode_btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        check("bounce_mode_hold", mode, 0);
        mode_btn_n = 1'b0;
        tick(10);
        check("bounce_mode", mode, 1);
        tick(10);
        check("no_autorepeat", mode, 1);
        mode_btn_n = 1'b1;
        tick(10);
        check("release_mode", mode, 1);

        // Reach mode 2, level 101, then reset mid-operation
        press_a();
        btn_n = 3'b010;
        tick(10);
        check("pre_rst_mode", mode, 2);
        check("pre_rst_level", level, 3'b101);
        check("pre_rst_led", led, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mode", mode, 0);
        check("midrst_level", level, 0);
        check("midrst_led", led, 1);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check("requal_early", level, 0);
        tick(1);
        check("requal_level", level, 3'b101);

        // Mode button held through reset counts as one fresh press
        mode_btn_n = 1'b0;
        tick(2);
        #2 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("held_mode_early", mode, 0);
        tick(1);
        check("held_mode", mode, 1);
        tick(10);
        check("held_mode_stay", mode, 1);
        mode_btn_n = 1'b1;
        tick(10);

        // Wide instance, active-high LED, XOR mode
        for (int i = 0; i < 2; i++) begin
            mode_btn_n_b = 1'b0;
            tick(10);
            mode_btn_n_b = 1'b1;
            tick(10);
        end
        check("b_mode_xor", mode_b, 2);
        btn_n_b = 8'b1111_1000;
        tick(10);
        check("b_level7", level_b, 8'b0000_0111);
        check("b_led_odd", led_b, 1);
        btn_n_b = 8'b1111_1100;
        tick(10);
        check("b_level3", level_b, 8'b0000_0011);
        check("b_led_even", led_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_bank.md
# gate_bank

Parametrised debounced logic-gate unit for the board's push-button/LED path. It takes N active-low raw button inputs and one active-low mode button, then synchronises and debounces each one. It evaluates a selectable reduction function (AND, OR, XOR, NAND) over the debounced levels and drives one LED with configurable polarity. It sits directly between the board I/O pins and the LED pin, replacing the single fixed gate with its inverted-input workaround.

## Interface

- N_IN, 2, number of gate inputs; legal 2..8
- DEB_CYCLES, 250000, cycles a synchronised input must differ from its stable value before it is accepted; legal ≥ 2
- LED_ACTIVE_LOW, 1, 1: LED lit when `led` = 0; 0: LED lit when `led` = 1

Ports:

- clk  input  1  single system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_n  input  N_IN  raw buttons, active-low (0 = pressed), asynchronous to clk
- mode_btn_n  input  1  raw mode button, active-low, asynchronous
- led  output  1  gate result, polarity per LED_ACTIVE_LOW, registered
- mode  output  2  current function: 0 AND, 1 OR, 2 XOR, 3 NAND
- level  output  N_IN  debounced inputs, active-high (1 = pressed)

## Operation

- Reset (rst_n = 0, asynchronous):
  - synchroniser flops = 1 (released)
  - debounce counters = 0
  - level = 0, mode = 0
  - result register = 0, so led = LED_ACTIVE_LOW (LED dark)
- Synchroniser: each of the N_IN+1 raw inputs passes through a 2-flop chain. The inverted output s[i] is active-high.
- Debounce, per channel, identical for the mode channel:
  - s[i] == stable[i]: counter cleared.
  - s[i] != stable[i] and counter == DEB_CYCLES-1: stable[i] <= s[i], counter cleared.
  - Otherwise: counter increments.
  - A disagreement shorter than DEB_CYCLES cycles is discarded. A return to agreement restarts the count from 0.
- Counter width is clog2(DEB_CYCLES). The counter never wraps because it is bounded by the compare.
- Mode FSM: 4 states, AND→OR→XOR→NAND→AND. It advances exactly once per 0→1 transition of the debounced mode level. Release (1→0) has no effect, and holding the button does not auto-repeat.
- Function over level[N_IN-1:0]:
  - AND: &level
  - OR: |level
  - XOR: ^level (odd parity)
  - NAND: ~&level
- Result register: result <= f(mode, level) every cycle; led = result ^ LED_ACTIVE_LOW.
- No combinational path from any input to led.

## Timing

- Raw input change to level change: 2 (sync) + DEB_CYCLES cycles, ±1 cycle for async sampling.
- level or mode change to led change: 1 cycle, because result reads the registered level and mode.
- Mode press to mode change: 2 + DEB_CYCLES cycles. Mode is visible on the `mode` port on the same edge as the debounced level update.
- Simultaneous events:
  - Input level and mode update on the same edge: result on the next edge uses both new values.
  - Several input channels settling on the same edge: handled independently, no ordering.
- Reset mid-debounce: counter cleared and stable forced to 0. A button still held after reset is re-qualified from zero (2 + DEB_CYCLES). A held mode button becomes a fresh 0→1 press after release of reset, so mode advances to 1 once.
- Reset release: synchronous use only. Flops leave reset on the first rising clk after rst_n rises; no output changes earlier than 1 cycle after release.

## Test plan

Bench parameters: N_IN = 3, DEB_CYCLES = 4, LED_ACTIVE_LOW = 1, unless stated.

- Reset: rst_n = 0 asserted between clock edges → immediately led = 1, mode = 0, level = 000. Release with all buttons released → outputs unchanged for 20 cycles.
- Debounce: btn_n[0] low for 3 cycles then high → level stays 000. btn_n = 000 held steady → level = 111 after 6±1 cycles; led = 0 one cycle later (AND lit).
- Mode cycling: four clean presses of mode_btn_n, each held 10 cycles, with level = 011 → mode 1, 2, 3, 0. led goes 0 (OR), 1 (XOR: even count, dark), 0 (NAND), 1 (AND: not all set, dark).
- Bounce: mode_btn_n toggles every 2 cycles for 20 cycles, then held low → exactly one mode increment.
- Reset mid-operation: assert rst_n with mode = 2 and level = 101 → mode = 0, level = 000, led = 1 asynchronously. With buttons still held after release → level = 101 after 6±1 cycles.
- Polarity/width: N_IN = 8, LED_ACTIVE_LOW = 0, mode XOR, level = 00000111 → led = 1. Level = 00000011 → led = 0.
